// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcode map, requester limits and
// the layout of the issue register that feeds the shared ALU.
package alu_arbiter_pkg;

  // Upper bound on requesters and the tag width that covers it.
  localparam int unsigned ARB_NREQ_MAX = 4;
  localparam int unsigned ARB_IDW_MAX  = 2;

  // ALU opcode map, shared with the ALU and the control unit.
  // Shift opcodes shift operand B by A[4:0].
  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_SLL  = 4'd4;
  localparam logic [3:0] ALU_SRL  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  // Issue register: operands, opcode and the tag of the requester that issued.
  typedef struct packed {
    logic [31:0]            a;
    logic [31:0]            b;
    logic [3:0]             op;
    logic [ARB_IDW_MAX-1:0] id;
  } issue_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Single-cycle 32-bit ALU. Purely combinational; undefined opcodes pass A.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluop,
  output logic [31:0] c,
  output logic        zero
);

  logic [4:0] shamt;

  assign shamt = a[4:0];

  // Opcode decode and result select.
  always_comb begin
    c = a;
    case (aluop)
      ALU_AND:  c = a & b;
      ALU_OR:   c = a | b;
      ALU_ADD:  c = a + b;
      ALU_XOR:  c = a ^ b;
      ALU_SLL:  c = b << shamt;
      ALU_SRL:  c = b >> shamt;
      ALU_SUB:  c = a - b;
      ALU_SLT:  c = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: c = {31'd0, a < b};
      ALU_SRA:  c = $unsigned($signed(b) >>> shamt);
      ALU_NOR:  c = ~(a | b);
      default:  c = a;
    endcase
  end

  assign zero = (c == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters.
// Two-stage pipeline: issue register, then registered tagged result.
// Optional feature: define ALU_ARB_LOCK_EN to let a requester lock the ALU.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ*4-1:0]    req_op,
  input  logic [NREQ-1:0]      req_lock,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_c,
  output logic                 rsp_zero
);

  localparam logic [IDW-1:0] LastId = IDW'(NREQ - 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] rr_win;
  logic           rr_found;
  logic [IDW-1:0] grant_id;
  logic           grant_ok;
  logic           ptr_upd;
  logic           hs;

  issue_t         s1_d, s1_q;
  logic           s1_valid_q;

  logic [31:0]    alu_c;
  logic           alu_zero;

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [31:0]    rsp_c_q;
  logic           rsp_zero_q;

  // Round-robin pick: first valid requester at or after ptr, wrapping.
  always_comb begin
    int unsigned idx;
    rr_found = 1'b0;
    rr_win   = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!rr_found && req_valid[idx]) begin
        rr_found = 1'b1;
        rr_win   = IDW'(idx);
      end
    end
  end

`ifdef ALU_ARB_LOCK_EN
  logic           locked_q, locked_d;
  logic [IDW-1:0] owner_q, owner_d;

  // While locked only the owner can win; the pointer freezes until it unlocks.
  always_comb begin
    grant_id = locked_q ? owner_q : rr_win;
    grant_ok = locked_q ? req_valid[owner_q] : rr_found;
    ptr_upd  = hs && !(locked_q && req_lock[owner_q]);
    locked_d = locked_q;
    owner_d  = owner_q;
    if (hs) begin
      locked_d = req_lock[grant_id];
      if (req_lock[grant_id]) begin
        owner_d = grant_id;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^req_lock;

  // Pure round-robin: the pick is the grant.
  always_comb begin
    grant_id = rr_win;
    grant_ok = rr_found;
    ptr_upd  = hs;
  end
`endif

  // One-hot ready, handshake and next pointer.
  always_comb begin
    req_ready = '0;
    if (grant_ok) begin
      req_ready[grant_id] = 1'b1;
    end
    // A grant only exists for a valid requester, so it is always a transfer.
    hs    = grant_ok;
    ptr_d = ptr_q;
    if (ptr_upd) begin
      ptr_d = (grant_id == LastId) ? '0 : grant_id + 1'b1;
    end
  end

  // Issue-register contents for the granted requester.
  always_comb begin
    s1_d    = '0;
    s1_d.a  = req_a[32*grant_id +: 32];
    s1_d.b  = req_b[32*grant_id +: 32];
    s1_d.op = req_op[4*grant_id +: 4];
    s1_d.id = ARB_IDW_MAX'(grant_id);
  end

  // Pointer and stage-1 issue register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= hs;
      if (hs) begin
        s1_q <= s1_d;
      end
    end
  end

  alu_arbiter_alu u_alu (
    .a     (s1_q.a),
    .b     (s1_q.b),
    .aluop (s1_q.op),
    .c     (alu_c),
    .zero  (alu_zero)
  );

  // Stage-2 result register; payload only updates with a valid op.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_c_q     <= '0;
      rsp_zero_q  <= 1'b0;
    end else begin
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_q   <= IDW'(s1_q.id);
        rsp_c_q    <= alu_c;
        rsp_zero_q <= alu_zero;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one two-requester and one three-requester DUT.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rstn;

  // Two-requester DUT
  logic [1:0]  v2, ready2, lock2;
  logic [63:0] a2, b2;
  logic [7:0]  op2;
  logic        rv2, rid2, rz2;
  logic [31:0] rc2;

  // Three-requester DUT
  logic [2:0]  v3, ready3, lock3;
  logic [95:0] a3, b3;
  logic [11:0] op3;
  logic        rv3, rz3;
  logic [1:0]  rid3;
  logic [31:0] rc3;

  int checks = 0;
  int errors = 0;

  logic [31:0] sa [5];
  logic [31:0] sb [5];
  logic [3:0]  sop [5];
  logic [31:0] sc [5];
  logic [2:0]  gexp [5];
  logic [1:0]  gseq [5];

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(2)) dut2 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (v2),
    .req_ready (ready2),
    .req_a     (a2),
    .req_b     (b2),
    .req_op    (op2),
    .req_lock  (lock2),
    .rsp_valid (rv2),
    .rsp_id    (rid2),
    .rsp_c     (rc2),
    .rsp_zero  (rz2)
  );

  alu_arbiter #(.NREQ(3)) dut3 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (v3),
    .req_ready (ready3),
    .req_a     (a3),
    .req_b     (b3),
    .req_op    (op3),
    .req_lock  (lock3),
    .rsp_valid (rv3),
    .rsp_id    (rid3),
    .rsp_c     (rc3),
    .rsp_zero  (rz3)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    v2 = '0; lock2 = '0; a2 = '0; b2 = '0; op2 = '0;
    v3 = '0; lock3 = '0; a3 = '0; b3 = '0; op3 = '0;
    sa   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd0, 32'h0000_1234};
    sb   = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd0};
    sop  = '{ALU_SLT, ALU_SLTU, ALU_SLL, ALU_NOR, 4'hF};
    sc   = '{32'd1, 32'd0, 32'd16, 32'hFFFF_FFFF, 32'h0000_1234};
    gexp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    gseq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    rstn = 1'b0;
    cyc();
    cyc();

    // Reset state
    check("rst_valid", rv2, 0);
    check("rst_id", rid2, 0);
    check("rst_c", rc2, 0);
    check("rst_zero", rz2, 0);
    check("rst_ready", ready2, 0);
    check("rst_valid3", rv3, 0);
    rstn = 1'b1;
    cyc();

    // Single request: 5 + 3 from requester 0
    v2 = 2'b01; a2[31:0] = 32'd5; b2[31:0] = 32'd3; op2[3:0] = ALU_ADD;
    #1;
    check("single_ready", ready2, 2'b01);
    cyc();
    v2 = 2'b00;
    #1;
    check("single_lat1", rv2, 0);
    cyc();
    check("single_valid", rv2, 1);
    check("single_id", rid2, 0);
    check("single_c", rc2, 8);
    check("single_zero", rz2, 0);
    cyc();
    check("single_drop", rv2, 0);

    // Contention: 7 - 7 from both, grants alternate from requester 0
    do_reset();
    a2 = {32'd7, 32'd7}; b2 = {32'd7, 32'd7}; op2 = {ALU_SUB, ALU_SUB};
    for (int i = 0; i < 7; i++) begin
      v2 = (i < 4) ? 2'b11 : 2'b00;
      #1;
      if (i < 4) check("cont_ready", ready2, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i >= 2 && i < 6) begin
        check("cont_valid", rv2, 1);
        check("cont_id", rid2, (i - 2) % 2);
        check("cont_c", rc2, 0);
        check("cont_zero", rz2, 1);
      end else begin
        check("cont_idle", rv2, 0);
      end
      cyc();
    end

    // Opcode sweep via requester 1, back to back
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        v2 = 2'b10; a2[63:32] = sa[i]; b2[63:32] = sb[i]; op2[7:4] = sop[i];
      end else begin
        v2 = 2'b00;
      end
      #1;
      if (i < 5) check("sweep_ready", ready2, 2'b10);
      if (i >= 2) begin
        check("sweep_valid", rv2, 1);
        check("sweep_id", rid2, 1);
        check("sweep_c", rc2, sc[i-2]);
        check("sweep_zero", rz2, (sc[i-2] == 32'd0) ? 1 : 0);
      end
      cyc();
    end

    // Lock request from requester 1, then requester 0 waits
    v2 = 2'b10; lock2 = 2'b10; op2[7:4] = ALU_ADD;
    #1;
    check("lock_ready1", ready2, 2'b10);
    cyc();
    v2 = 2'b01; lock2 = 2'b00;
    #1;
`ifdef ALU_ARB_LOCK_EN
    check("lock_hold0", ready2, 2'b00);
    cyc();
    check("lock_hold1", ready2, 2'b00);
    cyc();
    v2 = 2'b11;
    #1;
    check("lock_owner", ready2, 2'b10);
    cyc();
    v2 = 2'b01;
    #1;
    check("lock_release", ready2, 2'b01);
`else
    check("lock_ignored", ready2, 2'b01);
`endif
    cyc();
    v2 = 2'b00;
    cyc();
    cyc();
    cyc();

    // Reset the cycle after a handshake: op is dropped, pointer restarts at 0
    v2 = 2'b01; a2[31:0] = 32'd5; b2[31:0] = 32'd3; op2[3:0] = ALU_ADD;
    #1;
    check("mid_ready", ready2, 2'b01);
    cyc();
    v2 = 2'b00;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", rv2, 0);
    check("mid_rst_c", rc2, 0);
    check("mid_rst_id", rid2, 0);
    check("mid_rst_zero", rz2, 0);
    check("mid_rst_ready", ready2, 0);
    cyc();
    check("mid_rst_valid2", rv2, 0);
    cyc();
    rstn = 1'b1;
    #1;
    check("mid_post_valid", rv2, 0);
    v2 = 2'b11;
    #1;
    check("mid_first_grant", ready2, 2'b01);
    cyc();
    v2 = 2'b00;
    #1;
    check("mid_post_valid2", rv2, 0);
    cyc();
    check("mid_new_valid", rv2, 1);
    check("mid_new_c", rc2, 8);

    // Three requesters: pointer wraps 0,1,2,0 then requester 1 alone
    a3 = {32'd2, 32'd1, 32'd0}; b3 = '0; op3 = {ALU_ADD, ALU_ADD, ALU_ADD};
    for (int i = 0; i < 7; i++) begin
      v3 = (i < 4) ? 3'b111 : ((i == 4) ? 3'b010 : 3'b000);
      #1;
      if (i < 5) check("wrap_ready", ready3, gexp[i]);
      if (i >= 2) begin
        check("wrap_valid", rv3, 1);
        check("wrap_id", rid3, gseq[i-2]);
        check("wrap_c", rc3, gseq[i-2]);
      end
      cyc();
    end
    check("wrap_idle", rv3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
